// File: rtl/shot_ctl.sv
// Shot controller: turns left-button presses into hit/miss decisions against the
// current duck box and keeps per-duck shots, per-game score and duck count.
module shot_ctl #(
  parameter int DUCK_WIDTH     = 64,
  parameter int DUCK_HEIGHT    = 64,
  parameter int SHOTS_PER_DUCK = 3,
  parameter int DUCKS_PER_GAME = 10,
  parameter int HOLD_CYCLES    = 65_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enable,
  input  logic        left_mouse,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [11:0] duck_xpos,
  input  logic [11:0] duck_ypos,
  output logic        duck_hit,
  output logic        duck_escaped,
  output logic        new_duck,
  output logic [1:0]  shots_left,
  output logic [7:0]  score,
  output logic [7:0]  duck_count,
  output logic        game_finished
);

  // Handshake: there is no valid/ready pairing here; game_enable is a level,
  // left_mouse is a level sampled every cycle, and the three event outputs are
  // single-cycle registered strobes that the consumer must take when high.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    HIT_HOLD  = 3'd2,
    MISS_HOLD = 3'd3,
    FINISHED  = 3'd4
  } state_e;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    SHOTS_INIT = 2'(SHOTS_PER_DUCK);
  localparam logic [7:0]    DUCKS_LAST = 8'(DUCKS_PER_GAME);

  state_e        state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          left_q;
  logic          duck_hit_q, duck_hit_d;
  logic          duck_escaped_q, duck_escaped_d;
  logic          new_duck_q, new_duck_d;
  logic [1:0]    shots_q, shots_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    count_q, count_d;
  logic          fin_q, fin_d;

  logic        click;
  logic        hit;
  logic [12:0] x_end, y_end;

  assign click = left_mouse & ~left_q;

  // Box edges are summed at 13 bits so a duck near the screen edge cannot wrap.
  assign x_end = {1'b0, duck_xpos} + 13'(DUCK_WIDTH);
  assign y_end = {1'b0, duck_ypos} + 13'(DUCK_HEIGHT);
  assign hit   = (mouse_xpos >= duck_xpos) && ({1'b0, mouse_xpos} < x_end) &&
                 (mouse_ypos >= duck_ypos) && ({1'b0, mouse_ypos} < y_end);

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    duck_hit_d     = 1'b0;
    duck_escaped_d = 1'b0;
    new_duck_d     = 1'b0;
    shots_d        = shots_q;
    score_d        = score_q;
    count_d        = count_q;
    fin_d          = fin_q;
    if (!game_enable) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      fin_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ARMED;
          score_d    = 8'd0;
          count_d    = 8'd0;
          shots_d    = SHOTS_INIT;
          fin_d      = 1'b0;
          new_duck_d = 1'b1;
        end
        ARMED: begin
          if (click) begin
            shots_d = shots_q - 2'd1;
            if (hit) begin
              score_d    = score_q + 8'd1;
              duck_hit_d = 1'b1;
              hold_cnt_d = '0;
              state_d    = HIT_HOLD;
            end else if (shots_q <= 2'd1) begin
              duck_escaped_d = 1'b1;
              hold_cnt_d     = '0;
              state_d        = MISS_HOLD;
            end
          end
        end
        HIT_HOLD, MISS_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            count_d    = count_q + 8'd1;
            if (count_q + 8'd1 == DUCKS_LAST) begin
              fin_d   = 1'b1;
              state_d = FINISHED;
            end else begin
              shots_d    = SHOTS_INIT;
              new_duck_d = 1'b1;
              state_d    = ARMED;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        FINISHED: state_d = FINISHED;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      left_q         <= 1'b0;
      duck_hit_q     <= 1'b0;
      duck_escaped_q <= 1'b0;
      new_duck_q     <= 1'b0;
      shots_q        <= 2'd0;
      score_q        <= 8'd0;
      count_q        <= 8'd0;
      fin_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      left_q         <= left_mouse;
      duck_hit_q     <= duck_hit_d;
      duck_escaped_q <= duck_escaped_d;
      new_duck_q     <= new_duck_d;
      shots_q        <= shots_d;
      score_q        <= score_d;
      count_q        <= count_d;
      fin_q          <= fin_d;
    end
  end

  assign duck_hit      = duck_hit_q;
  assign duck_escaped  = duck_escaped_q;
  assign new_duck      = new_duck_q;
  assign shots_left    = shots_q;
  assign score         = score_q;
  assign duck_count    = count_q;
  assign game_finished = fin_q;

endmodule

// File: doc/shot_ctl.md
Name: shot_ctl

Overview:
- Closes the gameplay loop opposite the duck drawing path.
- Consumes mouse clicks and the current duck position, decides hit or miss, and tracks shots, score and ducks per round.
- Drives feedback to the game: `duck_hit`, `duck_escaped` and `new_duck` to duck control, and `game_finished` to the game control FSM.
- Sits in the game control top level between the mouse inputs and `duck_ctl`/`game_control_fsm`.

Parameters:
- DUCK_WIDTH, 64, duck sprite width in pixels (hit box X extent)
- DUCK_HEIGHT, 64, duck sprite height in pixels (hit box Y extent)
- SHOTS_PER_DUCK, 3, shots available per duck; legal range 1..3
- DUCKS_PER_GAME, 10, ducks per game; legal range 1..255
- HOLD_CYCLES, 65_000_000, clk cycles spent in the hit/escape animation hold; must be ≥1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- game_enable  in  1  level from the game control FSM; high while in the game state
- left_mouse  in  1  left button level, synchronous to clk
- mouse_xpos  in  12  cursor X
- mouse_ypos  in  12  cursor Y
- duck_xpos  in  12  duck top-left X
- duck_ypos  in  12  duck top-left Y
- duck_hit  out  1  one-cycle pulse on a hit
- duck_escaped  out  1  one-cycle pulse when the last shot misses
- new_duck  out  1  one-cycle pulse requesting a fresh duck spawn
- shots_left  out  2  remaining shots for the current duck
- score  out  8  ducks hit this game
- duck_count  out  8  ducks completed this game
- game_finished  out  1  level; high once DUCKS_PER_GAME ducks are completed

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, all outputs 0, left_q=0.
- Click edge detection:
  - left_q registers left_mouse every cycle, in every state.
  - click = left_mouse & ~left_q.
  - A button already held when a state is entered produces no click.
- Hit test, combinational, evaluated on the click cycle:
  - hit = (mouse_x ≥ duck_x) && (mouse_x < duck_x+DUCK_WIDTH) && (mouse_y ≥ duck_y) && (mouse_y < duck_y+DUCK_HEIGHT).
  - Sums are computed at 13 bits; no wrap near 4095.
  - Right and bottom edges are exclusive.
- State IDLE:
  - Outputs score/duck_count hold their last values, so the end screen can display them.
  - game_enable high → go to ARMED; on that edge score=0, duck_count=0, shots_left=SHOTS_PER_DUCK, game_finished=0, and new_duck pulses the next cycle.
  - Clicks are ignored.
- State ARMED, on a click:
  - If hit: score+1, duck_hit pulses next cycle, go to HIT_HOLD.
  - If miss and shots_left>1: shots_left-1, stay in ARMED.
  - If miss and shots_left==1: shots_left=0, duck_escaped pulses next cycle, go to MISS_HOLD.
  - A hit also decrements shots_left; a hit on the last shot counts as a hit and produces no escape.
- States HIT_HOLD / MISS_HOLD:
  - Hold counter starts at 0 and increments each cycle; clicks are ignored.
  - When counter == HOLD_CYCLES-1: duck_count+1.
  - If the new duck_count == DUCKS_PER_GAME: go to FINISHED with game_finished=1.
  - Otherwise: shots_left=SHOTS_PER_DUCK, new_duck pulses the next cycle, go to ARMED.
  - The hold therefore lasts exactly HOLD_CYCLES cycles.
- State FINISHED:
  - game_finished stays high; clicks are ignored.
  - game_enable low → IDLE; game_finished clears and score/duck_count are kept.
- game_enable low in any state: go to IDLE on the next edge; no pulses are emitted that cycle; the hold counter clears.
- Priority: game_enable low > hold expiry > click.
- Pulses (duck_hit, duck_escaped, new_duck) are registered, exactly 1 cycle wide, and never overlap one another.
- score and duck_count never exceed DUCKS_PER_GAME.
- Reset mid-operation returns to IDLE immediately with all outputs 0.

Test Plan:
- Reset, then raise game_enable → new_duck is one 1-cycle pulse; shots_left=3, score=0, duck_count=0, game_finished=0.
- duck at (100,200), click at (100,200), then a click at (163,263) for a later duck at the same position → each is a hit: duck_hit pulses 1 cycle, score increments, duck_count increments after HOLD_CYCLES=4. A click at (164,200) → miss.
- Three misses at (0,0) with duck at (500,500) → shots_left goes 3→2→1→0; duck_escaped pulses once; score unchanged; after 4 cycles new_duck pulses and shots_left=3.
- Hold left_mouse high across entering ARMED, and separately click during HIT_HOLD → no shot consumed in either case; a release followed by a press then registers.
- DUCKS_PER_GAME=2, hit both ducks → game_finished rises after the second hold; further clicks ignored; game_enable low → game_finished=0 while score=2 is retained.
- Assert rst low mid-MISS_HOLD → all outputs 0 asynchronously; after release and game_enable high, a fresh game starts with shots_left=3.
